// File: rtl/udp_receive.sv
// UDP/IPv4 receive parser for the GMII RX domain: locks onto preamble/SFD, filters on the
// local MAC/IP/port, streams the UDP payload and reports sender info and FCS status per frame.
module udp_receive #(
  parameter bit BROADCAST_EN = 1'b1
) (
  input  logic        clk_125m,
  input  logic        reset,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_udp_port,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [15:0] rx_data_length,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_udp_port,
  output logic        rx_done,
  output logic        rx_crc_ok,
  output logic        rx_error
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned PRE_W = 3;
  localparam logic [7:0]       PRE_BYTE    = 8'h55;
  localparam logic [7:0]       SFD_BYTE    = 8'hd5;
  localparam logic [31:0]      CRC_POLY    = 32'hedb88320;
  localparam logic [31:0]      CRC_INIT    = 32'hffffffff;
  localparam logic [31:0]      CRC_RESIDUE = 32'hdebb20e3;
  localparam logic [CNT_W-1:0] ETH_LAST    = CNT_W'(13);
  localparam logic [CNT_W-1:0] IP_LAST     = CNT_W'(19);
  localparam logic [CNT_W-1:0] UDP_LAST    = CNT_W'(7);
  localparam logic [PRE_W-1:0] PRE_MAX     = PRE_W'(7);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, DONE, DROP
  } state_t;

  state_t           state, state_nxt;
  logic             dv_prev;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
  logic             mac_local_ok, mac_local_ok_nxt;
  logic             mac_bcast_ok, mac_bcast_ok_nxt;
  logic [7:0]       hi_byte, hi_byte_nxt;
  logic [15:0]      len_q, len_q_nxt;
  logic [15:0]      csum, csum_nxt;
  logic [31:0]      crc, crc_nxt;
  logic [47:0]      mac_sh, mac_sh_nxt;
  logic [31:0]      ip_sh, ip_sh_nxt;
  logic [15:0]      port_sh, port_sh_nxt;
  logic [15:0]      remain, remain_nxt;
  logic             first, first_nxt;

  logic [7:0]  rx_data_nxt;
  logic        rx_data_valid_nxt, rx_sof_nxt, rx_eof_nxt;
  logic [15:0] rx_data_length_nxt;
  logic [47:0] src_mac_nxt;
  logic [31:0] src_ip_nxt;
  logic [15:0] src_udp_port_nxt;
  logic        rx_done_nxt, rx_crc_ok_nxt, rx_error_nxt;

  logic [7:0]  mac_byte_c, ip_byte_c, port_byte_c;
  logic [16:0] csum_sum_c;
  logic [15:0] csum_add_c;
  logic [31:0] crc_upd_c;
  logic        mac_local_c, mac_bcast_c, ip_bad_c;

  function automatic logic [31:0] crc32_step(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte-wise selectors of the local addresses and per-byte header checks
  always_comb begin
    mac_byte_c  = 8'h00;
    ip_byte_c   = 8'h00;
    case (cnt)
      CNT_W'(0):  mac_byte_c = local_mac[47:40];
      CNT_W'(1):  mac_byte_c = local_mac[39:32];
      CNT_W'(2):  mac_byte_c = local_mac[31:24];
      CNT_W'(3):  mac_byte_c = local_mac[23:16];
      CNT_W'(4):  mac_byte_c = local_mac[15:8];
      CNT_W'(5):  mac_byte_c = local_mac[7:0];
      default: ;
    endcase
    case (cnt)
      CNT_W'(16): ip_byte_c = local_ip[31:24];
      CNT_W'(17): ip_byte_c = local_ip[23:16];
      CNT_W'(18): ip_byte_c = local_ip[15:8];
      CNT_W'(19): ip_byte_c = local_ip[7:0];
      default: ;
    endcase
    port_byte_c = (cnt == CNT_W'(2)) ? local_udp_port[15:8] : local_udp_port[7:0];
    mac_local_c = mac_local_ok && (gmii_rxd == mac_byte_c);
    mac_bcast_c = mac_bcast_ok && (gmii_rxd == 8'hff);
    csum_sum_c  = {1'b0, csum} + {1'b0, hi_byte, gmii_rxd};
    csum_add_c  = csum_sum_c[15:0] + 16'(csum_sum_c[16]);
    crc_upd_c   = crc32_step(crc, gmii_rxd);
    ip_bad_c    = ((cnt == CNT_W'(0)) && (gmii_rxd != 8'h45)) ||
                  ((cnt == CNT_W'(9)) && (gmii_rxd != 8'd17)) ||
                  ((cnt >= CNT_W'(16)) && (gmii_rxd != ip_byte_c)) ||
                  ((cnt == IP_LAST) && (csum_add_c != 16'hffff));
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    pre_cnt_nxt        = pre_cnt;
    mac_local_ok_nxt   = mac_local_ok;
    mac_bcast_ok_nxt   = mac_bcast_ok;
    hi_byte_nxt        = hi_byte;
    len_q_nxt          = len_q;
    csum_nxt           = csum;
    crc_nxt            = crc;
    mac_sh_nxt         = mac_sh;
    ip_sh_nxt          = ip_sh;
    port_sh_nxt        = port_sh;
    remain_nxt         = remain;
    first_nxt          = first;
    rx_data_nxt        = rx_data;
    rx_data_valid_nxt  = 1'b0;
    rx_sof_nxt         = 1'b0;
    rx_eof_nxt         = 1'b0;
    rx_data_length_nxt = rx_data_length;
    src_mac_nxt        = src_mac;
    src_ip_nxt         = src_ip;
    src_udp_port_nxt   = src_udp_port;
    rx_done_nxt        = 1'b0;
    rx_crc_ok_nxt      = 1'b0;
    rx_error_nxt       = 1'b0;

    if (gmii_rx_dv && (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER})) begin
      crc_nxt = crc_upd_c;
    end

    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        // A frame only starts on a dv rising edge
        if (gmii_rx_dv && !dv_prev) begin
          if (gmii_rxd == PRE_BYTE) begin
            state_nxt   = PREAMBLE;
            pre_cnt_nxt = PRE_W'(1);
          end else begin
            state_nxt = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_nxt        = ETH_HDR;
          cnt_nxt          = '0;
          crc_nxt          = CRC_INIT;
          mac_local_ok_nxt = 1'b1;
          mac_bcast_ok_nxt = BROADCAST_EN;
        end else if ((gmii_rxd == PRE_BYTE) && (pre_cnt != PRE_MAX)) begin
          pre_cnt_nxt = pre_cnt + PRE_W'(1);
        end else begin
          state_nxt = DROP;
        end
      end
      ETH_HDR: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else if (cnt < CNT_W'(6)) begin
          mac_local_ok_nxt = mac_local_c;
          mac_bcast_ok_nxt = mac_bcast_c;
          if (!mac_local_c && !mac_bcast_c) state_nxt = DROP;
        end else if (cnt < CNT_W'(12)) begin
          mac_sh_nxt = {mac_sh[39:0], gmii_rxd};
        end else if (cnt == CNT_W'(12)) begin
          if (gmii_rxd != 8'h08) state_nxt = DROP;
        end else if (gmii_rxd != 8'h00) begin
          state_nxt = DROP;
        end else if (cnt == ETH_LAST) begin
          state_nxt = IP_HDR;
          cnt_nxt   = '0;
          csum_nxt  = '0;
        end
      end
      IP_HDR: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!cnt[0]) hi_byte_nxt = gmii_rxd;
        else         csum_nxt    = csum_add_c;
        if ((cnt >= CNT_W'(12)) && (cnt < CNT_W'(16))) ip_sh_nxt = {ip_sh[23:0], gmii_rxd};
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else if (ip_bad_c) begin
          state_nxt = DROP;
        end else if (cnt == IP_LAST) begin
          state_nxt = UDP_HDR;
          cnt_nxt   = '0;
        end
      end
      UDP_HDR: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!gmii_rx_dv) begin
          state_nxt = IDLE;
        end else begin
          case (cnt)
            CNT_W'(0), CNT_W'(1): port_sh_nxt = {port_sh[7:0], gmii_rxd};
            CNT_W'(2), CNT_W'(3): if (gmii_rxd != port_byte_c) state_nxt = DROP;
            CNT_W'(4): hi_byte_nxt = gmii_rxd;
            CNT_W'(5): begin
              len_q_nxt = {hi_byte, gmii_rxd};
              if ({hi_byte, gmii_rxd} <= 16'd8) state_nxt = DROP;
            end
            UDP_LAST: begin
              state_nxt          = PAYLOAD;
              src_mac_nxt        = mac_sh;
              src_ip_nxt         = ip_sh;
              src_udp_port_nxt   = port_sh;
              rx_data_length_nxt = len_q - 16'd8;
              remain_nxt         = len_q - 16'd8;
              first_nxt          = 1'b1;
            end
            default: ;
          endcase
        end
      end
      PAYLOAD: begin
        if (gmii_rx_dv) begin
          rx_data_nxt       = gmii_rxd;
          rx_data_valid_nxt = 1'b1;
          rx_sof_nxt        = first;
          rx_eof_nxt        = (remain == 16'd1);
          first_nxt         = 1'b0;
          remain_nxt        = remain - 16'd1;
          if (remain == 16'd1) state_nxt = TRAILER;
        end else begin
          state_nxt    = DONE;
          rx_done_nxt  = 1'b1;
          rx_error_nxt = 1'b1;
        end
      end
      TRAILER: begin
        if (!gmii_rx_dv) begin
          state_nxt     = DONE;
          rx_done_nxt   = 1'b1;
          rx_crc_ok_nxt = (crc == CRC_RESIDUE);
        end
      end
      DROP: begin
        if (!gmii_rx_dv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dv_prev resets high so a frame already in flight at reset release is ignored
  always_ff @(posedge clk_125m or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dv_prev        <= 1'b1;
      cnt            <= '0;
      pre_cnt        <= '0;
      mac_local_ok   <= 1'b0;
      mac_bcast_ok   <= 1'b0;
      hi_byte        <= '0;
      len_q          <= '0;
      csum           <= '0;
      crc            <= CRC_INIT;
      mac_sh         <= '0;
      ip_sh          <= '0;
      port_sh        <= '0;
      remain         <= '0;
      first          <= 1'b0;
      rx_data        <= '0;
      rx_data_valid  <= 1'b0;
      rx_sof         <= 1'b0;
      rx_eof         <= 1'b0;
      rx_data_length <= '0;
      src_mac        <= '0;
      src_ip         <= '0;
      src_udp_port   <= '0;
      rx_done        <= 1'b0;
      rx_crc_ok      <= 1'b0;
      rx_error       <= 1'b0;
    end else begin
      state          <= state_nxt;
      dv_prev        <= gmii_rx_dv;
      cnt            <= cnt_nxt;
      pre_cnt        <= pre_cnt_nxt;
      mac_local_ok   <= mac_local_ok_nxt;
      mac_bcast_ok   <= mac_bcast_ok_nxt;
      hi_byte        <= hi_byte_nxt;
      len_q          <= len_q_nxt;
      csum           <= csum_nxt;
      crc            <= crc_nxt;
      mac_sh         <= mac_sh_nxt;
      ip_sh          <= ip_sh_nxt;
      port_sh        <= port_sh_nxt;
      remain         <= remain_nxt;
      first          <= first_nxt;
      rx_data        <= rx_data_nxt;
      rx_data_valid  <= rx_data_valid_nxt;
      rx_sof         <= rx_sof_nxt;
      rx_eof         <= rx_eof_nxt;
      rx_data_length <= rx_data_length_nxt;
      src_mac        <= src_mac_nxt;
      src_ip         <= src_ip_nxt;
      src_udp_port   <= src_udp_port_nxt;
      rx_done        <= rx_done_nxt;
      rx_crc_ok      <= rx_crc_ok_nxt;
      rx_error       <= rx_error_nxt;
    end
  end

endmodule

// File: tb/tb_udp_receive.sv
// Self-checking bench for udp_receive: builds complete Ethernet/IPv4/UDP frames with their
// own header checksum and FCS, and scores the payload stream and end-of-frame reports.
module tb_udp_receive;

  localparam logic [47:0] LOCAL_MAC  = 48'h000a3501fec0;
  localparam logic [31:0] LOCAL_IP   = 32'hc0a80002;
  localparam logic [15:0] LOCAL_PORT = 16'd5000;
  localparam logic [47:0] PEER_MAC   = 48'hc85b76dd0b38;
  localparam logic [31:0] PEER_IP    = 32'hc0a80003;
  localparam logic [15:0] PEER_PORT  = 16'd6102;
  localparam int          HDR_BYTES  = 8 + 14 + 20 + 8;

  logic        clk_125m = 1'b0;
  logic        reset = 1'b1;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_data_valid, rx_sof, rx_eof;
  logic [15:0] rx_data_length;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_udp_port;
  logic        rx_done, rx_crc_ok, rx_error;

  always #4 clk_125m = ~clk_125m;

  udp_receive #(.BROADCAST_EN(1'b1)) dut (
    .clk_125m       (clk_125m),
    .reset          (reset),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rxd       (gmii_rxd),
    .local_mac      (LOCAL_MAC),
    .local_ip       (LOCAL_IP),
    .local_udp_port (LOCAL_PORT),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_sof         (rx_sof),
    .rx_eof         (rx_eof),
    .rx_data_length (rx_data_length),
    .src_mac        (src_mac),
    .src_ip         (src_ip),
    .src_udp_port   (src_udp_port),
    .rx_done        (rx_done),
    .rx_crc_ok      (rx_crc_ok),
    .rx_error       (rx_error)
  );

  typedef struct packed {logic [7:0] data; logic sof; logic eof;} beat_t;
  typedef struct packed {logic crc_ok; logic err;} done_t;

  beat_t      exp_beats[$];
  done_t      exp_done[$];
  logic [7:0] frm[$];
  int         n_assert = 0;
  int         n_fail = 0;
  string      golden = "Hello, welcome to FPGA!";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reflected CRC-32
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hedb88320;
    end
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dmac, input logic [7:0] proto,
                             input logic [15:0] dport, input string pl, input int npad,
                             input bit flip_csum, input bit bad_fcs);
    logic [7:0]  hdr[$];
    logic [31:0] sum, crc;
    logic [15:0] csum, ip_len, udp_len;
    ip_len  = 16'(28 + pl.len());
    udp_len = 16'(8 + pl.len());
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(8'h55);
    frm.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) hdr.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) hdr.push_back(PEER_MAC[8*i +: 8]);
    hdr.push_back(8'h08); hdr.push_back(8'h00);
    hdr.push_back(8'h45); hdr.push_back(8'h00); hdr.push_back(ip_len[15:8]); hdr.push_back(ip_len[7:0]);
    hdr.push_back(8'h00); hdr.push_back(8'h00); hdr.push_back(8'h40); hdr.push_back(8'h00);
    hdr.push_back(8'h40); hdr.push_back(proto); hdr.push_back(8'h00); hdr.push_back(8'h00);
    for (int i = 3; i >= 0; i--) hdr.push_back(PEER_IP[8*i +: 8]);
    for (int i = 3; i >= 0; i--) hdr.push_back(LOCAL_IP[8*i +: 8]);
    sum = 32'd0;
    for (int k = 0; k < 10; k++) sum = sum + {16'h0000, hdr[14+2*k], hdr[15+2*k]};
    while (sum[31:16] != 16'h0000) sum = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
    csum = ~sum[15:0];
    if (flip_csum) csum = csum ^ 16'h0001;
    hdr[24] = csum[15:8];
    hdr[25] = csum[7:0];
    hdr.push_back(PEER_PORT[15:8]); hdr.push_back(PEER_PORT[7:0]);
    hdr.push_back(dport[15:8]); hdr.push_back(dport[7:0]);
    hdr.push_back(udp_len[15:8]); hdr.push_back(udp_len[7:0]);
    hdr.push_back(8'h00); hdr.push_back(8'h00);
    for (int i = 0; i < pl.len(); i++) hdr.push_back(pl[i]);
    for (int i = 0; i < npad; i++) hdr.push_back(8'h00);
    crc = 32'hffffffff;
    foreach (hdr[i]) crc = crc_bits(crc, hdr[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) hdr.push_back(crc[8*i +: 8]);
    if (bad_fcs) hdr[hdr.size()-1] = hdr[hdr.size()-1] ^ 8'h01;
    foreach (hdr[i]) frm.push_back(hdr[i]);
  endtask

  task automatic expect_payload(input string pl, input int nbeats, input bit crc_ok, input bit err);
    beat_t b;
    done_t d;
    for (int i = 0; i < nbeats; i++) begin
      b.data = pl[i];
      b.sof  = (i == 0);
      b.eof  = (i == pl.len() - 1);
      exp_beats.push_back(b);
    end
    d.crc_ok = crc_ok;
    d.err    = err;
    exp_done.push_back(d);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_125m);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
    end
    @(negedge clk_125m);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (12) @(negedge clk_125m);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
    check({tag, "_done_left"}, 64'(exp_done.size()), 64'd0);
    exp_beats.delete();
    exp_done.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    check({tag, "_strobes"}, 64'({rx_data_valid, rx_sof, rx_eof, rx_done, rx_crc_ok, rx_error}), 64'd0);
    check({tag, "_len"}, 64'(rx_data_length), 64'd0);
    check({tag, "_src_mac"}, 64'(src_mac), 64'd0);
    check({tag, "_src_ip"}, 64'(src_ip), 64'd0);
    check({tag, "_src_port"}, 64'(src_udp_port), 64'd0);
  endtask

  task automatic check_info(input string tag, input logic [15:0] len);
    check({tag, "_len"}, 64'(rx_data_length), 64'(len));
    check({tag, "_src_mac"}, 64'(src_mac), 64'(PEER_MAC));
    check({tag, "_src_ip"}, 64'(src_ip), 64'(PEER_IP));
    check({tag, "_src_port"}, 64'(src_udp_port), 64'(PEER_PORT));
  endtask

  // Output monitor: scores every beat and every end-of-frame report against the queues
  initial forever begin
    beat_t eb;
    done_t ed;
    @(posedge clk_125m);
    #1;
    if (rx_data_valid) begin
      check("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
      if (exp_beats.size() != 0) begin
        eb = exp_beats.pop_front();
        check("rx_data", 64'(rx_data), 64'(eb.data));
        check("rx_sof", 64'(rx_sof), 64'(eb.sof));
        check("rx_eof", 64'(rx_eof), 64'(eb.eof));
      end
    end else if (rx_sof || rx_eof) begin
      check("strobe_without_valid", 64'({rx_sof, rx_eof}), 64'd0);
    end
    if (rx_done) begin
      check("done_expected", 64'(exp_done.size() != 0), 64'd1);
      if (exp_done.size() != 0) begin
        ed = exp_done.pop_front();
        check("rx_crc_ok", 64'(rx_crc_ok), 64'(ed.crc_ok));
        check("rx_error", 64'(rx_error), 64'(ed.err));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk_125m);
    check_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk_125m);

    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    expect_payload(golden, golden.len(), 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("golden");
    check_info("golden", 16'd23);

    build_frame(48'h000a3501fec1, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    send_bytes(frm.size());
    check_drained("wrong_mac");
    build_frame(LOCAL_MAC, 8'd17, 16'd5001, golden, 0, 1'b0, 1'b0);
    send_bytes(frm.size());
    check_drained("wrong_port");
    build_frame(LOCAL_MAC, 8'd6, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    send_bytes(frm.size());
    check_drained("wrong_proto");

    build_frame(48'hffffffffffff, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    expect_payload(golden, golden.len(), 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("broadcast");

    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, golden, 0, 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("bad_ip_csum");

    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b1);
    expect_payload(golden, golden.len(), 1'b0, 1'b0);
    send_bytes(frm.size());
    check_drained("bad_fcs");

    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, "FPGA!", 13, 1'b0, 1'b0);
    expect_payload("FPGA!", 5, 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("padded");
    check_info("padded", 16'd5);

    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    expect_payload(golden, 10, 1'b0, 1'b1);
    send_bytes(HDR_BYTES + 10);
    check_drained("truncated");
    expect_payload(golden, golden.len(), 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("after_trunc");

    // Reset in the middle of the payload, dv kept high through and after reset
    build_frame(LOCAL_MAC, 8'd17, LOCAL_PORT, golden, 0, 1'b0, 1'b0);
    expect_payload(golden, golden.len(), 1'b1, 1'b0);
    n = HDR_BYTES + 5;
    send_bytes_partial: for (int i = 0; i < n; i++) begin
      @(negedge clk_125m);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
    end
    for (int i = n; i < frm.size(); i++) begin
      @(negedge clk_125m);
      gmii_rxd = frm[i];
      if (i == n) begin
        reset = 1'b1;
        exp_beats.delete();
        exp_done.delete();
      end
      if (i == n + 2) begin
        check_zero("mid_reset");
        reset = 1'b0;
      end
    end
    @(negedge clk_125m);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (12) @(negedge clk_125m);
    check_drained("reset_frame");
    check_zero("post_reset");
    expect_payload(golden, golden.len(), 1'b1, 1'b0);
    send_bytes(frm.size());
    check_drained("after_reset");
    check_info("after_reset", 16'd23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
